// File: rtl/rv_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Optional macro RV_MULDIV_FAST_MUL_EN swaps the iterative multiply for a combinational one.
module rv_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned PW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

`ifdef RV_MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_n;

    logic [2:0]      op;
    logic            res_neg;
    logic [XLEN-1:0] divisor;
    logic [PW-1:0]   prod;
    logic [CW-1:0]   cnt;

    // Request decode: signedness, magnitudes, result sign and fast-path detection
    logic            in_div;
    logic            signed_a;
    logic            signed_b;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg_in;
    logic            div_zero;
    logic            div_ovf;
    logic            fast_div;
    logic            fast_mul_in;
    logic [XLEN-1:0] fast_res;
    logic            accept;

    assign in_div   = funct3_i[2];
    assign signed_a = !((funct3_i == 3'd3) || (funct3_i == 3'd5) || (funct3_i == 3'd7));
    assign signed_b = (funct3_i == 3'd0) || (funct3_i == 3'd1) ||
                      (funct3_i == 3'd4) || (funct3_i == 3'd6);
    assign sign_a   = signed_a & rs1_i[XLEN-1];
    assign sign_b   = signed_b & rs2_i[XLEN-1];
    assign mag_a    = sign_a ? (XLEN'(0) - rs1_i) : rs1_i;
    assign mag_b    = sign_b ? (XLEN'(0) - rs2_i) : rs2_i;
    // REM/REMU follow the dividend sign; everything else uses the XOR of both signs
    assign neg_in   = (in_div && funct3_i[1]) ? sign_a : (sign_a ^ sign_b);

    assign div_zero    = in_div && (rs2_i == '0);
    assign div_ovf     = in_div && !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    assign fast_div    = div_zero || div_ovf;
    assign fast_mul_in = FAST_MUL && !in_div;

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = funct3_i[1] ? rs1_i : '1;
        end else if (div_ovf) begin
            fast_res = funct3_i[1] ? '0 : rs1_i;
        end
    end

    assign accept  = (state == IDLE) && valid_i && !flush_i;
    assign ready_o = (state == IDLE);
    assign stall_o = (state == CALC) || (state == FIX) ||
                     ((state == IDLE) && valid_i && !flush_i);

    // One multiply step: conditional add into the upper half, keep carry, shift right
    logic [XLEN:0]   mul_sum;
    logic [PW-1:0]   mul_step;
    assign mul_sum  = {1'b0, prod[PW-1:XLEN]} + {1'b0, divisor};
    assign mul_step = prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[PW-1:1]};

    // One restoring divide step: remainder in upper half, quotient shifts in at the bottom
    logic [XLEN:0]   div_tmp;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [PW-1:0]   div_step;
    assign div_tmp  = prod[PW-1:XLEN-1];
    assign div_ge   = div_tmp >= {1'b0, divisor};
    assign div_diff = div_tmp[XLEN-1:0] - divisor;
    assign div_step = div_ge ? {div_diff, prod[XLEN-2:0], 1'b1}
                             : {div_tmp[XLEN-1:0], prod[XLEN-2:0], 1'b0};

    logic [PW-1:0] prod_mag;
`ifdef RV_MULDIV_FAST_MUL_EN
    assign prod_mag = op[2] ? prod : (PW'(prod[XLEN-1:0]) * PW'(divisor));
`else
    assign prod_mag = prod;
`endif

    // Sign fix-up and output select
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] div_sel;
    logic [XLEN-1:0] div_fix;
    logic [XLEN-1:0] fix_res;
    assign prod_fix = res_neg ? (PW'(0) - prod_mag) : prod_mag;
    assign div_sel  = op[1] ? prod_mag[PW-1:XLEN] : prod_mag[XLEN-1:0];
    assign div_fix  = res_neg ? (XLEN'(0) - div_sel) : div_sel;

    always_comb begin
        fix_res = '0;
        if (op[2]) begin
            fix_res = div_fix;
        end else if (op[1:0] == 2'd0) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[PW-1:XLEN];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fast_div) begin
                        state_n = DONE;
                    end else if (fast_mul_in) begin
                        state_n = FIX;
                    end else begin
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt == CW'(1)) begin
                    state_n = FIX;
                end
            end
            FIX:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush_i) begin
            state_n = IDLE;
        end
    end

    // Operand/product registers and the registered done/result outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op       <= '0;
            res_neg  <= 1'b0;
            divisor  <= '0;
            prod     <= '0;
            cnt      <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= (state_n == DONE);
            if ((state_n == DONE) && (state != DONE)) begin
                result_o <= (state == FIX) ? fix_res : fast_res;
            end
            if (accept) begin
                op      <= funct3_i;
                res_neg <= neg_in;
                divisor <= mag_b;
                prod    <= {{XLEN{1'b0}}, mag_a};
                cnt     <= (fast_div || fast_mul_in) ? '0 : CW'(XLEN);
            end else if (state == CALC) begin
                prod <= op[2] ? div_step : mul_step;
                cnt  <= cnt - CW'(1);
            end
        end
    end

endmodule
